// File: rtl/keypad_scan_display.sv
// 4x4 matrix keypad scanner with frame-based debouncing, feeding a
// NUM_DIGITS-deep shift buffer shown on a time-multiplexed seven-segment bus.
module keypad_scan_display #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int NUM_DIGITS      = 4,
  parameter int MUX_DIV         = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [3:0]            row,
  input  logic [3:0]            col,
  input  logic                  clear,
  output logic                  key_valid,
  output logic [3:0]            key_code,
  output logic                  key_down,
  output logic [6:0]            seg7,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MUX_W  = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_GHOST} res_t;
  typedef enum logic {IDLE, HELD} state_t;

  // Reset asserts asynchronously but is released in step with clk.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  // ---------------- row scan and per-frame closure accumulation ----------
  logic [SCAN_W-1:0] dwell_cnt_reg;
  logic [1:0]        row_idx_reg;
  logic [1:0]        acc_cnt_reg;
  logic [3:0]        acc_code_reg;
  logic              dwell_end;
  logic              frame_end;
  logic [3:0]        closed;
  logic [2:0]        n_closed;
  logic [1:0]        col_idx;
  logic [3:0]        sample_code;
  logic [1:0]        frame_cnt;
  logic [3:0]        frame_code;

  assign dwell_end = (dwell_cnt_reg == SCAN_W'(SCAN_DIV - 1));
  assign frame_end = dwell_end && (row_idx_reg == 2'd3);
  assign row       = ~(4'b0001 << row_idx_reg);
  assign closed    = ~col;
  assign n_closed  = 3'(closed[0]) + 3'(closed[1]) + 3'(closed[2]) + 3'(closed[3]);

  always_comb begin
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (closed[i]) col_idx = 2'(i);
    end
  end

  // Code is r*4+c+1 modulo 16, so r3 c3 wraps to 0.
  assign sample_code = {row_idx_reg, col_idx} + 4'd1;

  // Closure count saturates at 2: anything above one closure is a ghost.
  always_comb begin
    frame_cnt  = acc_cnt_reg;
    frame_code = acc_code_reg;
    if (n_closed == 3'd1 && acc_cnt_reg == 2'd0) begin
      frame_cnt  = 2'd1;
      frame_code = sample_code;
    end else if (n_closed != 3'd0) begin
      frame_cnt  = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt_reg <= '0;
      row_idx_reg   <= 2'd0;
      acc_cnt_reg   <= 2'd0;
      acc_code_reg  <= 4'd0;
    end else if (dwell_end) begin
      dwell_cnt_reg <= '0;
      row_idx_reg   <= row_idx_reg + 2'd1;
      if (frame_end) begin
        acc_cnt_reg  <= 2'd0;
        acc_code_reg <= 4'd0;
      end else begin
        acc_cnt_reg  <= frame_cnt;
        acc_code_reg <= frame_code;
      end
    end else begin
      dwell_cnt_reg <= dwell_cnt_reg + SCAN_W'(1);
    end
  end

  // ---------------- frame stability tracking ------------------------------
  res_t              res_kind;
  res_t              prev_kind_reg;
  logic [3:0]        prev_code_reg;
  logic [STAB_W-1:0] stab_reg;
  logic [STAB_W-1:0] stab_next;
  logic              same_result;
  logic              debounced;

  always_comb begin
    case (frame_cnt)
      2'd0:    res_kind = RES_NONE;
      2'd1:    res_kind = RES_KEY;
      default: res_kind = RES_GHOST;
    endcase
  end

  assign same_result = (res_kind != RES_GHOST) && (res_kind == prev_kind_reg) &&
                       ((res_kind != RES_KEY) || (frame_code == prev_code_reg));

  always_comb begin
    if (same_result) begin
      stab_next = (stab_reg == STAB_W'(DEBOUNCE_FRAMES)) ? stab_reg : stab_reg + STAB_W'(1);
    end else if (res_kind == RES_GHOST) begin
      stab_next = '0;
    end else begin
      stab_next = STAB_W'(1);
    end
  end

  assign debounced = (stab_next >= STAB_W'(DEBOUNCE_FRAMES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_kind_reg <= RES_NONE;
      prev_code_reg <= 4'd0;
      stab_reg      <= '0;
    end else if (frame_end) begin
      prev_kind_reg <= res_kind;
      prev_code_reg <= frame_code;
      stab_reg      <= stab_next;
    end
  end

  // ---------------- press/release FSM -------------------------------------
  state_t     state_reg, state_next;
  logic       key_valid_reg, key_valid_next;
  logic [3:0] key_code_reg, key_code_next;
  logic       key_down_reg, key_down_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'd0;
      key_down_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_valid_reg <= key_valid_next;
      key_code_reg  <= key_code_next;
      key_down_reg  <= key_down_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    key_valid_next = 1'b0;
    key_code_next  = key_code_reg;
    key_down_next  = key_down_reg;
    if (frame_end) begin
      case (state_reg)
        IDLE: begin
          if (res_kind == RES_KEY && debounced) begin
            state_next     = HELD;
            key_valid_next = 1'b1;
            key_code_next  = frame_code;
            key_down_next  = 1'b1;
          end
        end
        HELD: begin
          // Only a debounced all-open frame re-arms; other keys are ignored.
          if (res_kind == RES_NONE && debounced) begin
            state_next    = IDLE;
            key_down_next = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign key_down  = key_down_reg;

  // ---------------- display buffer: {valid, code} per digit ---------------
  logic [NUM_DIGITS-1:0][4:0] digits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [4:0] value_reg;
      logic [4:0] shift_in;
      if (gi == 0) begin : g_head
        assign shift_in = {1'b1, key_code_reg};
      end else begin : g_tail
        assign shift_in = digits[gi-1];
      end
      // clear has priority over a coincident key shift.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             value_reg <= 5'd0;
        else if (clear)         value_reg <= 5'd0;
        else if (key_valid_reg) value_reg <= shift_in;
      end
      assign digits[gi] = value_reg;
    end
  endgenerate

  // ---------------- display multiplexer -----------------------------------
  function automatic logic [6:0] glyph(input logic [4:0] d);
    logic [6:0] g;
    g = 7'b1111111;
    if (d[4]) begin
      case (d[3:0])
        4'h0: g = 7'b1000000;
        4'h1: g = 7'b1111001;
        4'h2: g = 7'b0100100;
        4'h3: g = 7'b0110000;
        4'h4: g = 7'b0011001;
        4'h5: g = 7'b0010010;
        4'h6: g = 7'b0000010;
        4'h7: g = 7'b1111000;
        4'h8: g = 7'b0000000;
        4'h9: g = 7'b0010000;
        4'hA: g = 7'b0001000;
        4'hB: g = 7'b0000011;
        4'hC: g = 7'b1000110;
        4'hD: g = 7'b0100001;
        4'hE: g = 7'b0000110;
        4'hF: g = 7'b0001110;
      endcase
    end
    return g;
  endfunction

  logic [MUX_W-1:0]      slot_cnt_reg;
  logic [IDX_W-1:0]      digit_idx_reg;
  logic [6:0]            seg7_reg;
  logic [NUM_DIGITS-1:0] an_reg;
  logic                  slot_end;

  assign slot_end = (slot_cnt_reg == MUX_W'(MUX_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_reg  <= '0;
      digit_idx_reg <= '0;
      seg7_reg      <= 7'b1111111;
      an_reg        <= '1;
    end else begin
      if (slot_end) begin
        slot_cnt_reg  <= '0;
        digit_idx_reg <= (digit_idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_reg + IDX_W'(1);
      end else begin
        slot_cnt_reg  <= slot_cnt_reg + MUX_W'(1);
      end
      // Enable and segments register together so they stay aligned.
      an_reg   <= ~(NUM_DIGITS'(1) << digit_idx_reg);
      seg7_reg <= glyph(digits[digit_idx_reg]);
    end
  end

  assign seg7 = seg7_reg;
  assign an   = an_reg;

endmodule
